// File: rtl/trigger_detect_if.sv
// Trigger detector control/status bundle.
// master: comp_1/2, trig_src/slope, arm, force_trig, sample_en, holdoff, post_count -> slave;
// slave: trig_pulse, capture_en, capture_done, trig_state -> master.
interface trigger_detect_if #(
  parameter int POST_W = 12
);
  logic              comp_1;
  logic              comp_2;
  logic              trig_src;
  logic              trig_slope;
  logic              arm;
  logic              force_trig;
  logic              sample_en;
  logic [15:0]       holdoff;
  logic [POST_W-1:0] post_count;
  logic              trig_pulse;
  logic              capture_en;
  logic              capture_done;
  logic [2:0]        trig_state;

  modport master (
    output comp_1, comp_2, trig_src, trig_slope,
    output arm, force_trig, sample_en,
    output holdoff, post_count,
    input  trig_pulse, capture_en, capture_done, trig_state
  );

  modport slave (
    input  comp_1, comp_2, trig_src, trig_slope,
    input  arm, force_trig, sample_en,
    input  holdoff, post_count,
    output trig_pulse, capture_en, capture_done, trig_state
  );
endinterface

// File: rtl/trigger_detect.sv
// Scope trigger: per-channel sync + glitch filter + edge detect, arm/holdoff/post FSM.
// Ports: clk_50mHz, reset_n (async low), bus (trigger_detect_if.slave). Option: TRIG_AUTO_EN.
module trigger_detect #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int POST_W      = 12
) (
  input logic             clk_50mHz,
  input logic             reset_n,
  trigger_detect_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HOLDOFF = 3'd1;
  localparam logic [2:0] S_ARMED   = 3'd2;
  localparam logic [2:0] S_POST    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [2:0]        r_state;
  logic [15:0]       r_hold;
  logic [POST_W-1:0] r_post;
  logic              r_trig_pulse;

  logic [1:0] w_comp;
  logic [1:0] w_rise;
  logic [1:0] w_fall;
  logic       w_edge;
  logic       w_auto;
  logic       w_fire;

  assign w_comp = {bus.comp_2, bus.comp_1};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [FW-1:0]          r_cnt;
    logic                   r_filt;
    logic                   r_prev;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    // Level changes only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk_50mHz or negedge reset_n) begin
      if (!reset_n) begin
        r_sync <= '0;
        r_cnt  <= '0;
        r_filt <= 1'b0;
        r_prev <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_comp[g]};
        r_prev <= r_filt;
        if (w_synced == r_filt) begin
          r_cnt <= '0;
        end else if (r_cnt == FW'(FILT_LEN - 1)) begin
          r_filt <= w_synced;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + FW'(1);
        end
      end
    end

    assign w_rise[g] = r_filt & ~r_prev;
    assign w_fall[g] = ~r_filt & r_prev;
  end

  // Mux after edge detection so a source switch never fakes an edge.
  assign w_edge = bus.trig_slope ? w_fall[bus.trig_src]
                                 : w_rise[bus.trig_src];

`ifdef TRIG_AUTO_EN
  logic [19:0] r_auto;

  always_ff @(posedge clk_50mHz or negedge reset_n) begin
    if (!reset_n) begin
      r_auto <= '0;
    end else if (r_state != S_ARMED) begin
      r_auto <= '0;
    end else begin
      r_auto <= r_auto + 20'd1;
    end
  end

  assign w_auto = (r_state == S_ARMED) && (r_auto == '1);
`else
  assign w_auto = 1'b0;
`endif

  assign w_fire = bus.force_trig | w_edge | w_auto;

  always_ff @(posedge clk_50mHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_hold       <= '0;
      r_post       <= '0;
      r_trig_pulse <= 1'b0;
    end else begin
      r_trig_pulse <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.arm) begin
            r_state <= S_HOLDOFF;
            r_hold  <= (bus.holdoff == 16'd0) ? 16'd1 : bus.holdoff;
          end
        end
        S_HOLDOFF: begin
          if (r_hold == 16'd1) begin
            r_state <= S_ARMED;
          end else begin
            r_hold <= r_hold - 16'd1;
          end
        end
        S_ARMED: begin
          if (w_fire) begin
            r_state      <= S_POST;
            r_post       <= bus.post_count;
            r_trig_pulse <= 1'b1;
          end
        end
        S_POST: begin
          if (bus.sample_en) begin
            if (r_post == '0) begin
              r_state <= S_DONE;
            end else begin
              r_post <= r_post - POST_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.trig_pulse   = r_trig_pulse;
  assign bus.capture_en   = (r_state == S_POST);
  assign bus.capture_done = (r_state == S_DONE);
  assign bus.trig_state   = r_state;

endmodule

// File: tb/tb_trigger_detect.sv
// Self-checking bench for trigger_detect (default build, defaults 2/3/12).
// Vector table per acquisition plus hand sequences for reset and ignore cases.
module tb_trigger_detect;
  localparam int PW = 12;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  trigger_detect_if #(.POST_W(PW)) bus();

  trigger_detect #(
    .SYNC_STAGES(2),
    .FILT_LEN(3),
    .POST_W(PW)
  ) dut (
    .clk_50mHz(clk),
    .reset_n(rst_n),
    .bus(bus)
  );

  typedef enum int {
    K_EDGE, K_GLITCH, K_FORCE, K_BOTH, K_TOGGLE, K_HOLD
  } kind_t;

  typedef struct {
    logic  src;
    logic  slope;
    logic  c1;
    logic  c2;
    kind_t kind;
    int    ch;
    int    hold;
    int    post;
    int    exp_pulses;
    int    exp_lat;
    int    exp_hold;
  } vec_t;

  typedef struct {
    int pulses;
    int lat;
    int hold;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_pulse = 0;
  int pulse_cyc = 0;
  int n_hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.trig_pulse) begin
      n_pulse   <= n_pulse + 1;
      pulse_cyc <= cyc;
    end
    if (bus.trig_state == 3'd1) n_hold <= n_hold + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic logic get_comp(input int ch);
    return (ch == 0) ? bus.comp_1 : bus.comp_2;
  endfunction

  task automatic set_comp(input int ch, input logic v);
    if (ch == 0) bus.comp_1 = v;
    else bus.comp_2 = v;
  endtask

  task automatic pulse_arm;
    bus.arm = 1'b1;
    tick;
    bus.arm = 1'b0;
  endtask

  task automatic pulse_force;
    bus.force_trig = 1'b1;
    tick;
    bus.force_trig = 1'b0;
  endtask

  task automatic wait_armed(input string nm);
    for (int i = 0; i < 200; i++) begin
      if (bus.trig_state == 3'd2) break;
      tick;
    end
    chk(nm, int'(bus.trig_state), 2);
  endtask

  task automatic run_post(input string nm, input int p);
    int bad;
    bad = 0;
    for (int s = 0; s <= p; s++) begin
      if (!(bus.capture_en && !bus.capture_done &&
            bus.trig_state == 3'd3)) bad++;
      bus.sample_en = 1'b1;
      tick;
      bus.sample_en = 1'b0;
      tick;
    end
    chk({nm, "_post_cycles_bad"}, bad, 0);
    chk({nm, "_done_state"}, int'(bus.trig_state), 4);
    chk({nm, "_capture_done"}, int'(bus.capture_done), 1);
    chk({nm, "_capture_en_off"}, int'(bus.capture_en), 0);
  endtask

  initial begin
    int h0;
    int p0;
    int k;
    exp_t e;
    string nm;

    vecs[0] = '{src:0, slope:0, c1:0, c2:0, kind:K_EDGE,   ch:0,
                hold:5,  post:3,    exp_pulses:1, exp_lat:6, exp_hold:5};
    vecs[1] = '{src:0, slope:0, c1:0, c2:0, kind:K_GLITCH, ch:0,
                hold:5,  post:3,    exp_pulses:0, exp_lat:0, exp_hold:5};
    vecs[2] = '{src:1, slope:1, c1:0, c2:1, kind:K_EDGE,   ch:1,
                hold:0,  post:0,    exp_pulses:1, exp_lat:6, exp_hold:1};
    vecs[3] = '{src:0, slope:0, c1:0, c2:0, kind:K_EDGE,   ch:1,
                hold:2,  post:1,    exp_pulses:0, exp_lat:0, exp_hold:2};
    vecs[4] = '{src:0, slope:0, c1:0, c2:0, kind:K_BOTH,   ch:0,
                hold:1,  post:2,    exp_pulses:1, exp_lat:6, exp_hold:1};
    vecs[5] = '{src:0, slope:0, c1:0, c2:1, kind:K_TOGGLE, ch:0,
                hold:3,  post:0,    exp_pulses:0, exp_lat:0, exp_hold:3};
    vecs[6] = '{src:0, slope:1, c1:1, c2:0, kind:K_FORCE,  ch:0,
                hold:4,  post:2,    exp_pulses:1, exp_lat:1, exp_hold:4};
    vecs[7] = '{src:0, slope:0, c1:0, c2:0, kind:K_HOLD,   ch:0,
                hold:20, post:0,    exp_pulses:0, exp_lat:0, exp_hold:20};
    vecs[8] = '{src:1, slope:0, c1:0, c2:0, kind:K_EDGE,   ch:1,
                hold:1,  post:4095, exp_pulses:1, exp_lat:6, exp_hold:1};

    rst_n          = 1'b0;
    bus.comp_1     = 1'b0;
    bus.comp_2     = 1'b0;
    bus.trig_src   = 1'b0;
    bus.trig_slope = 1'b0;
    bus.arm        = 1'b0;
    bus.force_trig = 1'b0;
    bus.sample_en  = 1'b0;
    bus.holdoff    = 16'd0;
    bus.post_count = '0;

    repeat (3) tick;
    chk("reset_outputs", int'({bus.trig_pulse, bus.capture_en,
        bus.capture_done, bus.trig_state}), 0);
    rst_n = 1'b1;
    tick;
    chk("idle_after_release", int'(bus.trig_state), 0);

    p0 = n_pulse;
    pulse_force;
    tick;
    chk("force_in_idle_pulses", n_pulse - p0, 0);
    chk("force_in_idle_state", int'(bus.trig_state), 0);

    for (int i = 0; i < 9; i++) begin
      nm = $sformatf("v%0d", i);
      bus.trig_src   = vecs[i].src;
      bus.trig_slope = vecs[i].slope;
      bus.comp_1     = vecs[i].c1;
      bus.comp_2     = vecs[i].c2;
      bus.holdoff    = 16'(vecs[i].hold);
      bus.post_count = PW'(vecs[i].post);
      repeat (10) tick;
      h0 = n_hold;
      p0 = n_pulse;
      k  = cyc;
      sb.push_back('{pulses:vecs[i].exp_pulses, lat:vecs[i].exp_lat,
                     hold:vecs[i].exp_hold});
      pulse_arm;
      if (vecs[i].kind == K_HOLD)
        set_comp(vecs[i].ch, !get_comp(vecs[i].ch));
      wait_armed({nm, "_armed"});
      k = cyc;
      case (vecs[i].kind)
        K_EDGE: set_comp(vecs[i].ch, !get_comp(vecs[i].ch));
        K_GLITCH: begin
          set_comp(vecs[i].ch, 1'b1);
          repeat (2) tick;
          set_comp(vecs[i].ch, 1'b0);
        end
        K_FORCE: pulse_force;
        K_BOTH: begin
          set_comp(vecs[i].ch, !get_comp(vecs[i].ch));
          repeat (5) tick;
          pulse_force;
        end
        K_TOGGLE: bus.trig_src = !bus.trig_src;
        default: ;
      endcase
      repeat (12) tick;
      e = sb.pop_front();
      chk({nm, "_holdoff_cycles"}, n_hold - h0, e.hold);
      chk({nm, "_pulses"}, n_pulse - p0, e.pulses);
      if (e.pulses == 1) begin
        chk({nm, "_latency"}, pulse_cyc - k, e.lat);
      end else begin
        chk({nm, "_still_armed"}, int'(bus.trig_state), 2);
        p0 = n_pulse;
        pulse_force;
        tick;
        chk({nm, "_forced_pulse"}, n_pulse - p0, 1);
      end
      run_post(nm, vecs[i].post);
    end

    bus.holdoff    = 16'd10;
    bus.post_count = PW'(5);
    bus.trig_src   = 1'b0;
    bus.trig_slope = 1'b0;
    repeat (10) tick;
    h0 = n_hold;
    pulse_arm;
    repeat (3) tick;
    pulse_arm;
    wait_armed("rearm_armed");
    chk("arm_in_holdoff_ignored", n_hold - h0, 10);

    p0 = n_pulse;
    repeat (3000) tick;
    chk("no_auto_pulses", n_pulse - p0, 0);
    chk("no_auto_state", int'(bus.trig_state), 2);

    pulse_force;
    chk("force_to_post", int'(bus.trig_state), 3);
    pulse_arm;
    chk("arm_in_post_ignored", int'(bus.trig_state), 3);
    bus.sample_en = 1'b1;
    tick;
    bus.sample_en = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_post", int'({bus.trig_pulse, bus.capture_en,
        bus.capture_done, bus.trig_state}), 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("idle_after_mid_post_reset", int'(bus.trig_state), 0);
    pulse_arm;
    chk("arm_after_reset", int'(bus.trig_state), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trigger_detect.md
TRIGGER_DETECT -- requirements
Module: trigger_detect

Interface
REQ-001 Parameter SYNC_STAGES, default 2, comparator synchronizer depth (min 2).
REQ-002 Parameter FILT_LEN, default 3, consecutive equal synced samples required before a filtered level changes (min 1).
REQ-003 Parameter POST_W, default 12, post-trigger counter width.
REQ-004 clk_50mHz  in  1  sole clock; every flop rises on it.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 comp_1  in  1  async ch1 comparator output (signal vs ref_level_1 via DAC).
REQ-007 comp_2  in  1  async ch2 comparator output (signal vs ref_level_2 via DAC).
REQ-008 trig_src  in  1  0 = ch1, 1 = ch2.
REQ-009 trig_slope  in  1  0 = rising, 1 = falling.
REQ-010 arm  in  1  single-cycle request to start an acquisition.
REQ-011 force_trig  in  1  single-cycle manual trigger.
REQ-012 sample_en  in  1  ADC sample strobe.
REQ-013 holdoff  in  16  holdoff cycles after arm.
REQ-014 post_count  in  POST_W  post-trigger samples minus one.
REQ-015 trig_pulse  out  1  one-cycle trigger event.
REQ-016 capture_en  out  1  high while post-trigger samples are taken.
REQ-017 capture_done  out  1  level, acquisition complete.
REQ-018 trig_state  out  3  IDLE=0, HOLDOFF=1, ARMED=2, POST=3, DONE=4.

Function
REQ-019 Each comp_x SHALL pass through its own SYNC_STAGES-flop synchronizer.
REQ-020 Each filtered level SHALL take the synced value only after FILT_LEN consecutive equal synced samples; shorter pulses SHALL be ignored.
REQ-021 Edge detection SHALL run independently per channel and be muxed by trig_src, so a trig_src change SHALL NOT create an edge.
REQ-022 Qualifying edge to trig_pulse SHALL take SYNC_STAGES+FILT_LEN+1 clocks from the first clock sampling the new comp level.
REQ-023 IDLE or DONE + arm -> HOLDOFF; holdoff loads and capture_done clears on that edge.
REQ-024 HOLDOFF SHALL last max(holdoff,1) cycles, then -> ARMED; edges during HOLDOFF SHALL be discarded.
REQ-025 ARMED + qualifying edge or force_trig -> POST with trig_pulse high exactly one cycle; a simultaneous edge and force_trig SHALL give one pulse.
REQ-026 POST: capture_en=1, counter loads post_count; on each sample_en, counter==0 -> DONE, else decrement; exactly post_count+1 strobes SHALL be consumed.
REQ-027 DONE: capture_done=1, capture_en=0, held until next arm.
REQ-028 arm in HOLDOFF, ARMED or POST, and force_trig outside ARMED, SHALL be ignored.
REQ-029 post_count=max (all ones) SHALL consume 2^POST_W strobes with no wrap error.

Reset
REQ-030 reset_n low SHALL asynchronously force state IDLE, all outputs 0, synchronizers, filters, edge history and counters 0, including mid-POST.
REQ-031 The first arm after reset release SHALL behave per REQ-023.

Configuration
REQ-032 TRIG_AUTO_EN defined: an ARMED period with no trigger for 2^20 cycles SHALL self-trigger exactly like force_trig; the timeout counter clears on ARMED entry.
REQ-033 TRIG_AUTO_EN undefined: ARMED SHALL wait indefinitely, and no timeout logic SHALL be synthesized.

Verification
REQ-034 Defaults, holdoff=5, arm, then comp_1 0->1 in ARMED, slope 0, src 0 -> one trig_pulse exactly 6 clocks after the first sampling clock; state 2->3.
REQ-035 2-clock high glitch on comp_1 while ARMED -> no trig_pulse, state stays 2.
REQ-036 post_count=3, 4 sample_en strobes after trigger -> capture_en high for all 4, capture_done=1 after the 4th strobe, state=4.
REQ-037 force_trig and qualifying edge in the same ARMED cycle -> single trig_pulse; trig_src toggle with stable comp levels -> none.
REQ-038 reset_n low mid-POST -> all outputs 0, state 0 immediately; arm after release -> HOLDOFF.
REQ-039 TRIG_AUTO_EN defined, armed, no edges -> trig_pulse 2^20 cycles after ARMED entry; undefined -> none after 2^21 cycles.
